// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : FSM state encoding (3 bits)
//   DefResetPc    : default PC loaded on reset
//   DefNopInstr   : default instruction word shown to decode when nothing is valid
//   PcStep        : sequential PC increment (16-bit instruction words)
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StHold  = 3'd2,
        StDrain = 3'd3,
        StHalt  = 3'd4
    } fetch_state_e;

    localparam logic [15:0] DefResetPc  = 16'h0000;
    localparam logic [15:0] DefNopInstr = 16'h0800;
    localparam logic [15:0] PcStep      = 16'h0002;

endpackage

// File: rtl/fetch_unit_cla16.sv
// 16-bit carry-lookahead adder built from four 4-bit groups.
// Sum is modulo 2^16; no carry-out is produced.
// Ports:
//   a_i, b_i : addends
//   cin_i    : carry into bit 0
//   sum_o    : a_i + b_i + cin_i (mod 2^16)
module fetch_unit_cla16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [2:0]  grp_g;
    logic [2:0]  grp_p;
    logic [3:0]  grp_c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;
        // Group generate/propagate; the top group's are not needed without a carry-out.
        for (int b = 0; b < 3; b++) begin
            grp_p[b] = &p[4*b +: 4];
            grp_g[b] = g[4*b+3]
                     | (p[4*b+3] & g[4*b+2])
                     | (p[4*b+3] & p[4*b+2] & g[4*b+1])
                     | (p[4*b+3] & p[4*b+2] & p[4*b+1] & g[4*b]);
        end
        grp_c[0] = cin_i;
        for (int b = 1; b < 4; b++) begin
            grp_c[b] = grp_g[b-1] | (grp_p[b-1] & grp_c[b-1]);
        end
        // Within each group, carries ripple from the looked-ahead group carry-in.
        for (int b = 0; b < 4; b++) begin
            c[4*b] = grp_c[b];
            for (int i = 1; i < 4; i++) begin
                c[4*b+i] = g[4*b+i-1] | (p[4*b+i-1] & c[4*b+i-1]);
            end
        end
    end

    assign sum_o = p ^ c;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over a req/done
// handshake and presents {instr, PC+2} to decode with valid/ready. Execute can
// redirect the PC at any time; an in-flight memory read is never aborted, it is
// drained and its data discarded.
// Optional build macro: FETCH_MISALIGN_CHK_EN -- an odd PC entering FETCH raises a
// sticky if_err_o and halts without issuing a request. Without it if_err_o stays 0
// and pc[0] goes to memory unchecked.
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   imem_req_o/addr_o    : read request, byte address (= PC), held until done
//   imem_rdata_i/done_i  : read data, one-cycle completion pulse
//   if_valid_o/instr_o   : instruction to decode (NOP_INSTR when not valid)
//   if_incpc_o           : PC+2 of the presented instruction
//   id_ready_i           : decode accepts (transfer = valid & ready)
//   pc_redirect_i/target : execute redirect and its NextPC
//   halt_in_i, halted_o  : HALT accepted by decode; fetch stopped until reset
//   if_err_o             : misaligned-PC fault
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = DefResetPc,
    parameter logic [15:0] NOP_INSTR = DefNopInstr
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic [15:0] imem_rdata_i,
    input  logic        imem_done_i,
    output logic        if_valid_o,
    output logic [15:0] if_instr_o,
    output logic [15:0] if_incpc_o,
    input  logic        id_ready_i,
    input  logic        pc_redirect_i,
    input  logic [15:0] pc_target_i,
    input  logic        halt_in_i,
    output logic        halted_o,
    output logic        if_err_o
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  instr_q, instr_d;
    logic [15:0]  incpc_q, incpc_d;
    logic         halt_pend_q, halt_pend_d;
    logic         err_q, err_d;
    logic         req_q, valid_q, halted_q;
    logic [15:0]  pc_plus2;
    logic         capture;

    fetch_unit_cla16 u_pc_add (
        .a_i   (pc_q),
        .b_i   (PcStep),
        .cin_i (1'b0),
        .sum_o (pc_plus2)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        incpc_d     = incpc_q;
        halt_pend_d = halt_pend_q;
        err_d       = err_q;
        capture     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pc_redirect_i) begin
                    pc_d    = pc_target_i;
                    state_d = StFetch;
                end else if (halt_in_i) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (pc_redirect_i) begin
                    // A redirect squashes a pending halt from a younger instruction.
                    pc_d        = pc_target_i;
                    halt_pend_d = 1'b0;
                    state_d     = imem_done_i ? StFetch : StDrain;
                end else if (imem_done_i) begin
                    if (halt_pend_q || halt_in_i) begin
                        state_d = StHalt;
                    end else begin
                        capture = 1'b1;
                        incpc_d = pc_plus2;
                        state_d = StHold;
                    end
                end else if (halt_in_i) begin
                    halt_pend_d = 1'b1;
                    state_d     = StDrain;
                end
            end
            StHold: begin
                if (pc_redirect_i) begin
                    pc_d    = pc_target_i;
                    state_d = StFetch;
                end else if (halt_in_i) begin
                    state_d = StHalt;
                end else if (id_ready_i) begin
                    pc_d    = pc_plus2;
                    state_d = StFetch;
                end
            end
            StDrain: begin
                if (pc_redirect_i) begin
                    pc_d        = pc_target_i;
                    halt_pend_d = 1'b0;
                end else if (halt_in_i) begin
                    halt_pend_d = 1'b1;
                end
                // The outstanding read may finish in the same cycle as a redirect.
                if (imem_done_i) begin
                    state_d = halt_pend_d ? StHalt : StFetch;
                end
            end
            StHalt: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef FETCH_MISALIGN_CHK_EN
        // Catch the odd PC before the request would go out.
        if ((state_d == StFetch) && pc_d[0]) begin
            state_d = StHalt;
            err_d   = 1'b1;
        end
`endif

        // Held word is only meaningful in HOLD; everywhere else decode sees a NOP.
        if (capture) begin
            instr_d = imem_rdata_i;
        end else if (state_d != StHold) begin
            instr_d = NOP_INSTR;
        end else begin
            instr_d = instr_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            incpc_q     <= '0;
            halt_pend_q <= 1'b0;
            err_q       <= 1'b0;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            incpc_q     <= incpc_d;
            halt_pend_q <= halt_pend_d;
            err_q       <= err_d;
            req_q       <= (state_d == StFetch);
            valid_q     <= (state_d == StHold);
            halted_q    <= (state_d == StHalt);
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;
    assign if_valid_o  = valid_q;
    assign if_instr_o  = instr_q;
    assign if_incpc_o  = incpc_q;
    assign halted_o    = halted_q;
    assign if_err_o    = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized phase. The expected
// instruction stream comes from an architectural PC model (start at RESET_PC,
// +2 per accepted instruction, jump on redirect) and is checked by a scoreboard.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP      = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_incpc;
    logic        id_ready;
    logic        pc_redirect;
    logic [15:0] pc_target;
    logic        halt_in;
    logic        halted;
    logic        if_err;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .imem_done_i   (imem_done),
        .if_valid_o    (if_valid),
        .if_instr_o    (if_instr),
        .if_incpc_o    (if_incpc),
        .id_ready_i    (id_ready),
        .pc_redirect_i (pc_redirect),
        .pc_target_i   (pc_target),
        .halt_in_i     (halt_in),
        .halted_o      (halted),
        .if_err_o      (if_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] incpc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] pc_model;

    // Memory model state
    int          mem_lat      = 0;
    bit          mem_lat_rand = 1'b0;
    bit          mem_busy     = 1'b0;
    int          mem_cnt;
    int          mem_wait;
    logic [15:0] mem_addr_lat;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'd3) ^ 16'hC35A;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h required %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.instr = mem_word(pc_model);
        e.incpc = pc_model + 16'd2;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        pc_model = RESET_PC;
        push_expect();
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input bit rdy, input bit redir, input logic [15:0] tgt, input bit hlt);
        @(posedge clk);
        #1;
        id_ready    = rdy;
        pc_redirect = redir;
        pc_target   = tgt;
        halt_in     = hlt;
        if (redir) begin
            exp_q.delete();
            pc_model = tgt;
            push_expect();
        end else if (hlt) begin
            exp_q.delete();
        end else if (if_valid && rdy) begin
            pc_model = pc_model + 16'd2;
            push_expect();
        end
    endtask

    task automatic wait_valid(input bit rdy, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(rdy, 1'b0, 16'h0000, 1'b0);
            @(negedge clk);
            if (if_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: if_valid still 0 after 30 cycles, required 1", name);
        end
    endtask

    task automatic wait_req(input bit rdy, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(rdy, 1'b0, 16'h0000, 1'b0);
            @(negedge clk);
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: imem_req still 0 after 30 cycles, required 1", name);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        id_ready    = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = 16'h0000;
        halt_in     = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check16("rst_req", {15'b0, imem_req}, 16'h0);
        check16("rst_valid", {15'b0, if_valid}, 16'h0);
        check16("rst_instr", if_instr, NOP);
        check16("rst_incpc", if_incpc, 16'h0000);
        check16("rst_halted", {15'b0, halted}, 16'h0);
        check16("rst_err", {15'b0, if_err}, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Variable-latency instruction memory; completes the outstanding read even
    // after the request line drops.
    always begin
        @(posedge clk);
        #1;
        imem_done  = 1'b0;
        imem_rdata = 16'($urandom);
        if (rst) begin
            mem_busy = 1'b0;
        end else begin
            if (!mem_busy && imem_req) begin
                mem_busy     = 1'b1;
                mem_cnt      = 0;
                mem_addr_lat = imem_addr;
                mem_wait     = mem_lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
            end
            if (mem_busy) begin
                if (mem_cnt >= mem_wait) begin
                    imem_done  = 1'b1;
                    imem_rdata = mem_word(mem_addr_lat);
                    mem_busy   = 1'b0;
                end else begin
                    mem_cnt++;
                end
            end
        end
    end

    // Scoreboard monitor
    logic        prev_req  = 1'b0;
    logic        prev_done = 1'b0;
    logic [15:0] prev_addr = 16'h0000;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (!if_valid) begin
                check16("nop_when_invalid", if_instr, NOP);
            end
            if (if_valid && id_ready && !pc_redirect && !halt_in) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: transfer instr=%h incpc=%h, required no transfer",
                             if_instr, if_incpc);
                end else begin
                    e = exp_q.pop_front();
                    check16("sb_instr", if_instr, e.instr);
                    check16("sb_incpc", if_incpc, e.incpc);
                end
            end
            if (prev_req && !prev_done && imem_req) begin
                check16("addr_stable", imem_addr, prev_addr);
            end
            prev_req  = imem_req;
            prev_done = imem_done;
            prev_addr = imem_addr;
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int x0;
        bit rdy;
        bit redir;
        logic [15:0] tgt;

        rst         = 1'b1;
        imem_done   = 1'b0;
        imem_rdata  = 16'h0000;
        id_ready    = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = 16'h0000;
        halt_in     = 1'b0;

        // Reset, zero-wait memory, decode always ready
        do_reset();
        @(negedge clk);
        check16("idle_no_req", {15'b0, imem_req}, 16'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 16'h0000, 1'b0);
            @(negedge clk);
            check16("seq_req", {15'b0, imem_req}, 16'h1);
            check16("seq_addr", imem_addr, 16'(2 * k));
            check16("seq_gap", {15'b0, if_valid}, 16'h0);
            cyc(1'b1, 1'b0, 16'h0000, 1'b0);
            @(negedge clk);
            check16("seq_valid", {15'b0, if_valid}, 16'h1);
            check16("seq_incpc", if_incpc, 16'(2 * k + 2));
        end

        // 3-cycle memory, decode stalls 4 cycles in HOLD
        mem_lat = 3;
        wait_valid(1'b0, "stall_valid");
        check16("stall_instr0", if_instr, mem_word(16'h0006));
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 16'h0000, 1'b0);
            @(negedge clk);
            check16("stall_hold_valid", {15'b0, if_valid}, 16'h1);
            check16("stall_hold_instr", if_instr, mem_word(16'h0006));
            check16("stall_hold_incpc", if_incpc, 16'h0008);
            check16("stall_no_req", {15'b0, imem_req}, 16'h0);
        end
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        check16("after_stall_req", {15'b0, imem_req}, 16'h1);
        check16("after_stall_addr", imem_addr, 16'h0008);

        // Redirect while FETCH waits on memory
        cyc(1'b0, 1'b1, 16'h0040, 1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        check16("drain_no_req", {15'b0, imem_req}, 16'h0);
        check16("drain_no_valid", {15'b0, if_valid}, 16'h0);
        wait_req(1'b1, "redir_req");
        check16("redir_addr", imem_addr, 16'h0040);
        wait_valid(1'b1, "redir_valid");
        check16("redir_instr", if_instr, mem_word(16'h0040));
        check16("redir_incpc", if_incpc, 16'h0042);

        // Redirect and transfer in the same HOLD cycle
        mem_lat = 1;
        wait_valid(1'b0, "rt_valid");
        cyc(1'b1, 1'b1, 16'h0100, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        check16("rt_dropped", {15'b0, if_valid}, 16'h0);
        check16("rt_req", {15'b0, imem_req}, 16'h1);
        check16("rt_addr", imem_addr, 16'h0100);
        wait_valid(1'b1, "rt_valid2");
        check16("rt_instr", if_instr, mem_word(16'h0100));

        // Halt in HOLD, then asynchronous reset out of HALT
        wait_valid(1'b0, "halt_valid");
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        check16("halted", {15'b0, halted}, 16'h1);
        check16("halted_no_valid", {15'b0, if_valid}, 16'h0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 1'b0, 16'h0000, 1'b0);
            @(negedge clk);
            if (imem_req || !halted) bad++;
        end
        check16("halt_quiet_cycles", 16'(bad), 16'h0);
        #2;
        rst = 1'b1;
        #1;
        check16("async_rst_halted", {15'b0, halted}, 16'h0);
        check16("async_rst_req", {15'b0, imem_req}, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        id_ready = 1'b0;
        model_reset();
        wait_req(1'b1, "restart_req");
        check16("restart_addr", imem_addr, RESET_PC);
        wait_valid(1'b1, "restart_valid");
        check16("restart_instr", if_instr, mem_word(RESET_PC));

        // PC wraps modulo 2^16
        cyc(1'b0, 1'b1, 16'hFFFE, 1'b0);
        wait_valid(1'b1, "wrap_valid");
        check16("wrap_instr", if_instr, mem_word(16'hFFFE));
        check16("wrap_incpc", if_incpc, 16'h0000);
        wait_req(1'b0, "wrap_req");
        check16("wrap_addr", imem_addr, 16'h0000);

        // Randomized traffic against the scoreboard
        mem_lat_rand = 1'b1;
        x0 = xfers;
        for (int k = 0; k < 600; k++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 9) == 0);
            tgt   = ($urandom_range(0, 7) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
            cyc(rdy, redir, tgt, 1'b0);
        end
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        checks++;
        if (xfers - x0 < 30) begin
            failures++;
            $display("FAIL random_progress: got %0d transfers, required at least 30", xfers - x0);
        end
        mem_lat_rand = 1'b0;
        mem_lat      = 0;

`ifdef FETCH_MISALIGN_CHK_EN
        // Odd redirect target: fault and halt without a request
        do_reset();
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 1'b1, 16'h0011, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        check16("mis_err", {15'b0, if_err}, 16'h1);
        check16("mis_halted", {15'b0, halted}, 16'h1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b0, 16'h0000, 1'b0);
            @(negedge clk);
            if (imem_req || !if_err || !halted) bad++;
        end
        check16("mis_quiet_cycles", 16'(bad), 16'h0);
`else
        check16("err_tied_low", {15'b0, if_err}, 16'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
